// File: rtl/div_sequencer.sv
// Iterative restoring divider for div/divu/rem/remu, BITS_PER_CYCLE quotient bits per CALC cycle.
// Build option: DIV_SEQUENCER_FASTPATH_EN skips the iteration for divide-by-zero and signed overflow.

module div_step (
  input  logic [31:0] r,
  input  logic [31:0] q,
  input  logic [31:0] d,
  output logic [31:0] r_n,
  output logic [31:0] q_n
);
  logic [32:0] sh, diff;
  logic        ge;

  // partial remainder stays below 2*d (or below 2^32 when d==0), so the borrow bit is the compare
  assign sh   = {r, q[31]};
  assign diff = sh - {1'b0, d};
  assign ge   = ~diff[32];
  assign r_n  = ge ? diff[31:0] : sh[31:0];
  assign q_n  = {q[30:0], ge};
endmodule

module div_sequencer #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        kill,
  input  logic [4:0]  operation,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic [31:0] res
);
  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  localparam logic [4:0] OP_DIV  = 5'b10011;
  localparam logic [4:0] OP_DIVU = 5'b10100;
  localparam logic [4:0] OP_REM  = 5'b10101;
  localparam logic [4:0] OP_REMU = 5'b10111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic [31:0]   r_q, q_q, d_q, a_q;
  logic          qneg_q, rneg_q, dz_q, rem_q;

  logic          op_ok, op_signed, op_rem, accept, in_dz;
  logic [31:0]   a_mag, b_mag, q_fix, r_fix, res_fix;

  assign op_ok     = (operation == OP_DIV) || (operation == OP_DIVU) ||
                     (operation == OP_REM) || (operation == OP_REMU);
  assign op_signed = (operation == OP_DIV) || (operation == OP_REM);
  assign op_rem    = (operation == OP_REM) || (operation == OP_REMU);
  assign accept    = (state == IDLE) && start && !kill && op_ok;
  assign in_dz     = (in2 == 32'd0);
  assign a_mag     = (op_signed && in1[31]) ? (~in1 + 32'd1) : in1;
  assign b_mag     = (op_signed && in2[31]) ? (~in2 + 32'd1) : in2;

`ifdef DIV_SEQUENCER_FASTPATH_EN
  logic        in_ov, fast;
  logic [31:0] fast_res;
  assign in_ov    = op_signed && (in1 == 32'h8000_0000) && (in2 == 32'hFFFF_FFFF);
  assign fast     = in_dz || in_ov;
  assign fast_res = op_rem ? (in_dz ? in1 : 32'd0) : (in_dz ? 32'hFFFF_FFFF : 32'h8000_0000);
`endif

  logic [BITS_PER_CYCLE:0][31:0] r_ch, q_ch;
  assign r_ch[0] = r_q;
  assign q_ch[0] = q_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    div_step u_step (
      .r   (r_ch[i]),
      .q   (q_ch[i]),
      .d   (d_q),
      .r_n (r_ch[i+1]),
      .q_n (q_ch[i+1])
    );
  end

  // overflow falls out of the magnitude math; only divide-by-zero needs an override
  assign q_fix   = dz_q ? 32'hFFFF_FFFF : (qneg_q ? (~q_q + 32'd1) : q_q);
  assign r_fix   = dz_q ? a_q : (rneg_q ? (~r_q + 32'd1) : r_q);
  assign res_fix = rem_q ? r_fix : q_fix;

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) begin
`ifdef DIV_SEQUENCER_FASTPATH_EN
        state_d = fast ? DONE : CALC;
`else
        state_d = CALC;
`endif
      end
      CALC:    if (cnt == CW'(N - 1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      a_q    <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      rem_q  <= 1'b0;
      res    <= '0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        r_q    <= '0;
        q_q    <= a_mag;
        d_q    <= b_mag;
        a_q    <= in1;
        qneg_q <= op_signed && (in1[31] ^ in2[31]);
        rneg_q <= op_signed && in1[31];
        dz_q   <= in_dz;
        rem_q  <= op_rem;
`ifdef DIV_SEQUENCER_FASTPATH_EN
        if (fast) res <= fast_res;
`endif
      end else if (state == CALC) begin
        cnt <= cnt + CW'(1);
        r_q <= r_ch[BITS_PER_CYCLE];
        q_q <= q_ch[BITS_PER_CYCLE];
      end
      if (state == FIX && !kill) res <= res_fix;
    end
  end

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer; runs BITS_PER_CYCLE=1 and =2 instances side by side on shared inputs.
module tb_div_sequencer;
  localparam logic [4:0] OP_DIV  = 5'b10011;
  localparam logic [4:0] OP_DIVU = 5'b10100;
  localparam logic [4:0] OP_REM  = 5'b10101;
  localparam logic [4:0] OP_REMU = 5'b10111;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, kill = 1'b0;
  logic [4:0]  operation = '0;
  logic [31:0] in1 = '0, in2 = '0;
  logic        busy1, done1, busy2, done2;
  logic [31:0] res1, res2;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  div_sequencer #(.BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .operation(operation),
    .in1(in1), .in2(in2), .busy(busy1), .done(done1), .res(res1));

  div_sequencer #(.BITS_PER_CYCLE(2)) u2 (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .operation(operation),
    .in1(in1), .in2(in2), .busy(busy2), .done(done2), .res(res2));

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; kill = 1'b1; operation = OP_DIV; in1 = 32'd9; in2 = 32'd3;
    repeat (3) @(negedge clk);
    tests++; if ({busy1, done1, busy2, done2} !== 4'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 0000", {busy1, done1, busy2, done2});
    end
    tests++; if (res1 !== 32'd0 || res2 !== 32'd0) begin
      fails++; $display("FAIL reset_res: got %h/%h want 0", res1, res2);
    end
    reset = 1'b0; start = 1'b0; kill = 1'b0;
    @(negedge clk);
  endtask

  // start in cycle 0; observe cycles 1..40 on both instances
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expv);
    int lat1 = 34, lat2 = 18, dc1 = -1, dc2 = -1, n1 = 0, n2 = 0;
    logic [31:0] r1 = '0, r2 = '0;
    logic bz1 = 1'b0;
    logic special;
    special = (b == 32'd0) || ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_SEQUENCER_FASTPATH_EN
    if (special) begin lat1 = 1; lat2 = 1; end
`endif
    @(negedge clk);
    operation = op; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b0; bz1 = busy1; end
      if (done1) begin n1++; if (dc1 < 0) begin dc1 = k; r1 = res1; end end
      if (done2) begin n2++; if (dc2 < 0) begin dc2 = k; r2 = res2; end end
    end
    tests++; if (dc1 != lat1 || n1 != 1) begin
      fails++; $display("FAIL %s done1: got cycle %0d x%0d want cycle %0d x1", name, dc1, n1, lat1);
    end
    tests++; if (dc2 != lat2 || n2 != 1) begin
      fails++; $display("FAIL %s done2: got cycle %0d x%0d want cycle %0d x1", name, dc2, n2, lat2);
    end
    tests++; if (r1 !== expv || r2 !== expv) begin
      fails++; $display("FAIL %s res: got %h/%h want %h", name, r1, r2, expv);
    end
    tests++; if (bz1 !== (lat1 != 1)) begin
      fails++; $display("FAIL %s busy_c1: got %b want %b", name, bz1, lat1 != 1);
    end
    tests++; if (res1 !== expv || res2 !== expv) begin
      fails++; $display("FAIL %s res_hold: got %h/%h want %h", name, res1, res2, expv);
    end
  endtask

  task automatic test_signed();
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("div_1000_m3", OP_DIV, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3);
    run_op("rem_1000_m3", OP_REM, 32'd1000, 32'hFFFF_FFFD, 32'd1);
  endtask

  task automatic test_unsigned();
    run_op("divu_ffff_16", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF);
    run_op("remu_ffff_16", OP_REMU, 32'hFFFF_FFFF, 32'd16, 32'd15);
  endtask

  task automatic test_special();
    run_op("div_by0", OP_DIV, 32'd123, 32'd0, 32'hFFFF_FFFF);
    run_op("div_neg_by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("rem_neg_by0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run_op("remu_by0", OP_REMU, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
  endtask

  task automatic test_kill();
    int dc1 = -1, dc2 = -1, n1 = 0, n2 = 0;
    logic [31:0] r1 = '0;
    @(negedge clk);
    operation = OP_DIV; in1 = 32'd100; in2 = 32'd7; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done1) begin n1++; if (dc1 < 0) begin dc1 = k; r1 = res1; end end
      if (done2) begin n2++; if (dc2 < 0) dc2 = k; end
      if (k == 1) start = 1'b0;
      if (k == 10) kill = 1'b1;
      if (k == 11) begin
        tests++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
          fails++; $display("FAIL kill_busy: got %b/%b want 0/0", busy1, busy2);
        end
        kill = 1'b0; start = 1'b1; in1 = 32'd100; in2 = 32'd7;
      end
      if (k == 12) start = 1'b0;
    end
    tests++; if (dc1 != 45 || n1 != 1 || dc2 != 29 || n2 != 1) begin
      fails++; $display("FAIL kill_restart: got %0dx%0d/%0dx%0d want 45x1/29x1", dc1, n1, dc2, n2);
    end
    tests++; if (r1 !== 32'd14) begin
      fails++; $display("FAIL kill_restart_res: got %h want %h", r1, 32'd14);
    end
    @(negedge clk);
    start = 1'b1; kill = 1'b1; operation = OP_DIVU; in1 = 32'd50; in2 = 32'd5;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    tests++; if ({busy1, done1, busy2, done2} !== 4'b0) begin
      fails++; $display("FAIL kill_over_start: got %b want 0000", {busy1, done1, busy2, done2});
    end
  endtask

  task automatic test_back_to_back();
    int dc1 = -1, dc2 = -1, n1 = 0, n2 = 0, late_busy2 = 0, bad = 0;
    logic [31:0] r1 = '0, r2 = '0;
    @(negedge clk);
    operation = OP_DIV; in1 = 32'd1000; in2 = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done1) begin n1++; if (dc1 < 0) begin dc1 = k; r1 = res1; end end
      if (done2) begin n2++; if (dc2 < 0) begin dc2 = k; r2 = res2; end end
      if ((k == 19 || k == 20) && busy2) late_busy2++;
      if (k == 1) begin operation = OP_REMU; in1 = 32'd77; in2 = 32'd5; end
      if (k == 19) start = 1'b0;
    end
    tests++; if (dc1 != 34 || n1 != 1 || dc2 != 18 || n2 != 1) begin
      fails++; $display("FAIL b2b_done: got %0dx%0d/%0dx%0d want 34x1/18x1", dc1, n1, dc2, n2);
    end
    tests++; if (r1 !== 32'hFFFF_FEB3 || r2 !== 32'hFFFF_FEB3) begin
      fails++; $display("FAIL b2b_res: got %h/%h want %h", r1, r2, 32'hFFFF_FEB3);
    end
    tests++; if (late_busy2 != 0) begin
      fails++; $display("FAIL start_in_done: got %0d busy cycles want 0", late_busy2);
    end
    @(negedge clk);
    operation = 5'b00000; in1 = 32'd10; in2 = 32'd2; start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy1 || busy2 || done1 || done2) bad++;
    end
    start = 1'b0;
    tests++; if (bad != 0) begin
      fails++; $display("FAIL bad_opcode: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    @(negedge clk);
    operation = OP_DIVU; in1 = 32'd12345; in2 = 32'd10; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 20) reset = 1'b1;
      if (k == 21) begin
        tests++; if ({busy1, done1, busy2, done2} !== 4'b0 || res1 !== 32'd0 || res2 !== 32'd0) begin
          fails++; $display("FAIL reset_mid: got %b %h %h want 0000 0 0",
                            {busy1, done1, busy2, done2}, res1, res2);
        end
        reset = 1'b0;
      end
      if (k > 21 && (done1 || done2)) n++;
    end
    tests++; if (n != 0) begin
      fails++; $display("FAIL reset_mid_done: got %0d pulses want 0", n);
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_special();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
